riscv_nn_instr_mem_responder: RTL and testbench



---
 rtl/riscv_nn_defines_pkg.sv | 21 ++
 rtl/riscv_nn_instr_mem_latency_pipe.sv | 47 ++++
 rtl/riscv_nn_instr_mem_responder.sv | 66 ++++++
 tb/tb_riscv_nn_instr_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_nn_defines_pkg.sv
// Shared constants and helpers for the riscv_nn instruction memory responder.
package riscv_nn_defines;

  localparam int          INSTR_MEM_MAX_LATENCY = 4;
  localparam logic [31:0] INSTR_MEM_BASE        = 32'h1C00_8000;

  // Wide enough to count every stage of the deepest supported pipeline.
  localparam int INSTR_MEM_OCC_W = $clog2(INSTR_MEM_MAX_LATENCY + 1);

  // 33-bit arithmetic so a window ending exactly at 4 GiB cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] bytes);
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + bytes));
  endfunction

endpackage

// File: rtl/riscv_nn_instr_mem_latency_pipe.sv
// Valid/data shift pipeline of DEPTH stages; the last stage is the response
// register and holds its data whenever no new valid word arrives.
module riscv_nn_instr_mem_latency_pipe
  import riscv_nn_defines::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int OCC_W = INSTR_MEM_OCC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  // NOTE: the default before the loop keeps this block free of latches.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/riscv_nn_instr_mem_responder.sv
// Instruction SRAM responder for the IF-stage fetch protocol: range check,
// outstanding-request cap, fixed read latency and a preload write port.
module riscv_nn_instr_mem_responder
  import riscv_nn_defines::*;
#(
  parameter int          RDATA_WIDTH     = 32,
  parameter int          MEM_WORDS       = 4096,
  parameter logic [31:0] BASE_ADDR       = INSTR_MEM_BASE,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0]       instr_rdata_o,
  output logic                         instr_err_pmp_o,
  input  logic                         gnt_stall_i,
  input  logic                         init_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr_i,
  input  logic [RDATA_WIDTH-1:0]       init_wdata_i
);

  localparam int          IDX_W        = $clog2(MEM_WORDS);
  localparam int          OFFSET_W     = $clog2(RDATA_WIDTH / 8);
  localparam logic [32:0] WINDOW_BYTES = 33'(MEM_WORDS) * 33'(RDATA_WIDTH / 8);
  localparam logic [INSTR_MEM_OCC_W:0] MAX_OCC = (INSTR_MEM_OCC_W + 1)'(MAX_OUTSTANDING);

  logic                       in_range;
  logic [IDX_W-1:0]           rd_index;
  logic [INSTR_MEM_OCC_W-1:0] occupancy;
  logic [RDATA_WIDTH-1:0]     mem [MEM_WORDS];

  assign in_range = in_window(instr_addr_i, BASE_ADDR, WINDOW_BYTES);
  // Index extracted only after the range check, so wrapping cannot alias.
  assign rd_index = instr_addr_i[OFFSET_W +: IDX_W];

  assign instr_err_pmp_o = instr_req_i & ~in_range;
  // Preload takes priority: a write cycle never also reads.
  assign instr_gnt_o = instr_req_i & in_range & ~gnt_stall_i & ~init_we_i &
                       ({1'b0, occupancy} < MAX_OCC);

  // NOTE: the array is deliberately not reset; contents come only from the
  // preload port, which also lets synthesis map it onto block RAM.
  always_ff @(posedge clk) begin
    if (init_we_i) mem[init_addr_i] <= init_wdata_i;
  end

  // The first pipeline stage is the synchronous read register.
  riscv_nn_instr_mem_latency_pipe #(
    .WIDTH (RDATA_WIDTH),
    .DEPTH (LATENCY),
    .OCC_W (INSTR_MEM_OCC_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (instr_gnt_o),
    .in_data   (mem[rd_index]),
    .out_valid (instr_rvalid_o),
    .out_data  (instr_rdata_o),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_riscv_nn_instr_mem_responder.sv
// Directed bench: three responder instances (latency 1, 3 and 2) driven by a
// linear sequence of steps with hand-computed expectations.
module tb_riscv_nn_instr_mem_responder;

  localparam logic [31:0] BASE = 32'h1C00_8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // a: LATENCY=1, MAX_OUTSTANDING=2, 64 words
  logic        a_req = 0, a_gnt, a_rvalid, a_err, a_stall = 0, a_we = 0;
  logic [31:0] a_addr = 0, a_rdata, a_wdata = 0;
  logic [5:0]  a_iaddr = 0;
  // b: LATENCY=3, MAX_OUTSTANDING=2, 16 words
  logic        b_req = 0, b_gnt, b_rvalid, b_err, b_stall = 0, b_we = 0;
  logic [31:0] b_addr = 0, b_rdata, b_wdata = 0;
  logic [3:0]  b_iaddr = 0;
  // c: LATENCY=2, MAX_OUTSTANDING=2, 16 words
  logic        c_req = 0, c_gnt, c_rvalid, c_err, c_stall = 0, c_we = 0;
  logic [31:0] c_addr = 0, c_rdata, c_wdata = 0;
  logic [3:0]  c_iaddr = 0;

  riscv_nn_instr_mem_responder #(
    .RDATA_WIDTH(32), .MEM_WORDS(64), .BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk(clk), .rst(rst), .instr_req_i(a_req), .instr_addr_i(a_addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
    .instr_err_pmp_o(a_err), .gnt_stall_i(a_stall), .init_we_i(a_we),
    .init_addr_i(a_iaddr), .init_wdata_i(a_wdata)
  );

  riscv_nn_instr_mem_responder #(
    .RDATA_WIDTH(32), .MEM_WORDS(16), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk(clk), .rst(rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
    .instr_err_pmp_o(b_err), .gnt_stall_i(b_stall), .init_we_i(b_we),
    .init_addr_i(b_iaddr), .init_wdata_i(b_wdata)
  );

  riscv_nn_instr_mem_responder #(
    .RDATA_WIDTH(32), .MEM_WORDS(16), .BASE_ADDR(BASE), .LATENCY(2), .MAX_OUTSTANDING(2)
  ) dut_c (
    .clk(clk), .rst(rst), .instr_req_i(c_req), .instr_addr_i(c_addr),
    .instr_gnt_o(c_gnt), .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata),
    .instr_err_pmp_o(c_err), .gnt_stall_i(c_stall), .init_we_i(c_we),
    .init_addr_i(c_iaddr), .init_wdata_i(c_wdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on
  // the following falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic a_write(input logic [5:0] idx, input logic [31:0] d);
    a_we = 1'b1; a_iaddr = idx; a_wdata = d;
    tick();
    a_we = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] idx, input logic [31:0] d);
    b_we = 1'b1; b_iaddr = idx; b_wdata = d;
    tick();
    b_we = 1'b0;
  endtask

  task automatic c_write(input logic [3:0] idx, input logic [31:0] d);
    c_we = 1'b1; c_iaddr = idx; c_wdata = d;
    tick();
    c_we = 1'b0;
  endtask

  logic [0:9] b_gnt_tab = 10'b1100110000;
  logic [0:9] b_rv_tab  = 10'b0001100110;
  int         b_ptr;
  int         b_rsp;

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    tick();
    tick();
    sample();
    check("a_reset_rvalid", a_rvalid, 1'b0);
    check("a_reset_rdata",  a_rdata,  32'h0);
    check("a_reset_gnt",    a_gnt,    1'b0);
    check("a_reset_err",    a_err,    1'b0);
    check("b_reset_rvalid", b_rvalid, 1'b0);
    check("b_reset_rdata",  b_rdata,  32'h0);
    check("b_reset_err",    b_err,    1'b0);
    check("c_reset_rvalid", c_rvalid, 1'b0);
    check("c_reset_err",    c_err,    1'b0);
    tick();
    rst = 1'b0;

    // ---------------- preload ----------------
    a_write(6'd0,  32'h0000_0013);
    a_write(6'd1,  32'h0010_0093);
    a_write(6'd10, 32'hDEAD_BEEF);
    a_write(6'd63, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) b_write(4'(i), 32'h100 + 32'(i));
    c_write(4'd0, 32'hA5A5_A5A5);

    // ---------------- LATENCY=1 back-to-back fetch ----------------
    a_req = 1'b1; a_addr = BASE;
    sample();
    check("a_b2b_gnt0", a_gnt, 1'b1);
    check("a_b2b_rv0",  a_rvalid, 1'b0);
    tick();
    a_addr = BASE + 32'h4;
    sample();
    check("a_b2b_gnt1",  a_gnt, 1'b1);
    check("a_b2b_rv1",   a_rvalid, 1'b1);
    check("a_b2b_data1", a_rdata, 32'h0000_0013);
    tick();
    a_req = 1'b0;
    sample();
    check("a_b2b_rv2",   a_rvalid, 1'b1);
    check("a_b2b_data2", a_rdata, 32'h0010_0093);
    tick();
    sample();
    check("a_hold_rv",   a_rvalid, 1'b0);
    check("a_hold_data", a_rdata, 32'h0010_0093);

    // ---------------- last word, ignored offset bits ----------------
    a_req = 1'b1; a_addr = BASE + 32'hFC;
    sample();
    check("a_last_gnt", a_gnt, 1'b1);
    check("a_last_err", a_err, 1'b0);
    tick();
    a_addr = BASE + 32'h2A;
    sample();
    check("a_unal_gnt",  a_gnt, 1'b1);
    check("a_last_data", a_rdata, 32'hCAFE_F00D);
    tick();
    a_req = 1'b0;
    sample();
    check("a_unal_rv",   a_rvalid, 1'b1);
    check("a_unal_data", a_rdata, 32'hDEAD_BEEF);
    tick();

    // ---------------- out-of-range requests ----------------
    a_req = 1'b1; a_addr = 32'h1C00_0000;
    sample();
    check("a_err_low_err", a_err, 1'b1);
    check("a_err_low_gnt", a_gnt, 1'b0);
    tick();
    a_addr = BASE - 32'h4;
    sample();
    check("a_err_below_err", a_err, 1'b1);
    check("a_err_below_gnt", a_gnt, 1'b0);
    tick();
    a_addr = BASE + 32'h100;
    sample();
    check("a_err_end_err", a_err, 1'b1);
    check("a_err_end_gnt", a_gnt, 1'b0);
    tick();
    a_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("a_err_no_rvalid", a_rvalid, 1'b0);
      check("a_err_idle", a_err, 1'b0);
      tick();
    end

    // ---------------- grant stall ----------------
    a_req = 1'b1; a_addr = BASE + 32'h4; a_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("a_stall_gnt", a_gnt, 1'b0);
      check("a_stall_rv", a_rvalid, 1'b0);
      tick();
    end
    a_stall = 1'b0;
    sample();
    check("a_unstall_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    sample();
    check("a_unstall_rv",   a_rvalid, 1'b1);
    check("a_unstall_data", a_rdata, 32'h0010_0093);
    tick();

    // ---------------- preload collides with read ----------------
    a_req = 1'b1; a_addr = BASE + 32'h14;
    a_we = 1'b1; a_iaddr = 6'd5; a_wdata = 32'h1234_5678;
    sample();
    check("a_we_blocks_gnt", a_gnt, 1'b0);
    tick();
    a_we = 1'b0;
    sample();
    check("a_we_next_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    sample();
    check("a_we_rv",   a_rvalid, 1'b1);
    check("a_we_data", a_rdata, 32'h1234_5678);
    tick();

    // ---------------- LATENCY=3, MAX_OUTSTANDING=2 ----------------
    b_ptr = 0;
    b_rsp = 0;
    for (int k = 0; k < 10; k++) begin
      b_req  = (k < 6);
      b_addr = BASE + 32'(b_ptr * 4);
      sample();
      check($sformatf("b_gnt_c%0d", k), b_gnt, b_gnt_tab[k]);
      check($sformatf("b_rv_c%0d", k), b_rvalid, b_rv_tab[k]);
      if (b_rv_tab[k]) begin
        check($sformatf("b_data_c%0d", k), b_rdata, 32'h100 + 32'(b_rsp));
        b_rsp++;
      end
      if (k == 5) check("b_data_hold", b_rdata, 32'h101);
      tick();
      if (b_gnt_tab[k]) b_ptr++;
    end
    b_req = 1'b0;

    // ---------------- LATENCY=2: latency and cap ----------------
    c_req = 1'b1; c_addr = BASE;
    sample();
    check("c_gnt0", c_gnt, 1'b1);
    tick();
    c_req = 1'b0;
    sample();
    check("c_rv_early", c_rvalid, 1'b0);
    tick();
    sample();
    check("c_rv_lat2",   c_rvalid, 1'b1);
    check("c_data_lat2", c_rdata, 32'hA5A5_A5A5);
    tick();
    c_req = 1'b1;
    sample();
    check("c_cap_g0", c_gnt, 1'b1);
    tick();
    sample();
    check("c_cap_g1", c_gnt, 1'b1);
    tick();
    sample();
    check("c_cap_g2", c_gnt, 1'b0);
    check("c_cap_rv", c_rvalid, 1'b1);
    tick();
    c_req = 1'b0;
    sample();
    check("c_cap_rv2", c_rvalid, 1'b1);
    tick();
    sample();
    check("c_cap_drained", c_rvalid, 1'b0);
    tick();

    // ---------------- reset one cycle after a grant ----------------
    c_req = 1'b1; c_addr = BASE;
    sample();
    check("c_rst_gnt", c_gnt, 1'b1);
    tick();
    c_req = 1'b0;
    rst = 1'b1;
    sample();
    check("c_rst_rv_during", c_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("c_rst_no_rvalid", c_rvalid, 1'b0);
      check("c_rst_rdata", c_rdata, 32'h0);
      check("c_rst_gnt_idle", c_gnt, 1'b0);
      check("c_rst_err_idle", c_err, 1'b0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
